// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: valid/ready byte stream from the UART receive FIFO to its consumer
interface uart_rx_fifo_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver (16x oversampled, 2-of-3 majority) feeding a FWFT byte FIFO
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 27_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          rx,
  uart_rx_fifo_if.master                m,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int DIV = (CLK_FREQ + 8 * BAUD) / (16 * BAUD);
  localparam int PW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t          state_q, state_d;
  logic [1:0]      sync_q;
  logic [PW-1:0]   presc_q, presc_d;
  logic [3:0]      tcnt_q, tcnt_d;
  logic [2:0]      bidx_q, bidx_d;
  logic            s7_q, s7_d, s8_q, s8_d;
  logic [7:0]      sh_q, sh_d;
  logic            fe_q, ov_q;
  logic [AW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic            rx_s, tick, maj, push, fe, pop, full, wr, ov;
  assign rx_s = sync_q[1];
  assign tick = presc_q == PW'(DIV - 1);
  assign maj  = (s7_q & s8_q) | (s7_q & rx_s) | (s8_q & rx_s);
  always_comb begin
    state_d = state_q;
    presc_d = tick ? '0 : presc_q + 1'b1;
    tcnt_d  = tick ? tcnt_q + 1'b1 : tcnt_q;
    s7_d    = (tick && tcnt_q == 4'd7) ? rx_s : s7_q;
    s8_d    = (tick && tcnt_q == 4'd8) ? rx_s : s8_q;
    bidx_d  = bidx_q;
    sh_d    = sh_q;
    push    = 1'b0;
    fe      = 1'b0;
    case (state_q)
      IDLE: if (!rx_s) begin
        state_d = START;
        presc_d = '0;
        tcnt_d  = '0;
      end
      START: begin
        if (tick && tcnt_q == 4'd9 && maj) state_d = IDLE;
        else if (tick && tcnt_q == 4'd15) begin
          state_d = DATA;
          bidx_d  = '0;
        end
      end
      DATA: begin
        if (tick && tcnt_q == 4'd9) sh_d = {maj, sh_q[7:1]};
        if (tick && tcnt_q == 4'd15) begin
          bidx_d  = bidx_q + 1'b1;
          state_d = (bidx_q == 3'd7) ? STOP : DATA;
        end
      end
      STOP: if (tick && tcnt_q == 4'd9) begin
        state_d = maj ? IDLE : BRK;
        push    = maj;
        fe      = !maj;
      end
      BRK: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // A push into a full FIFO is still accepted when the head leaves in the same cycle
  assign pop   = m.m_valid & m.m_ready;
  assign full  = cnt_q == CW'(FIFO_DEPTH);
  assign wr    = push & (!full | pop);
  assign ov    = push & full & !pop;
  assign cnt_d = cnt_q + CW'(wr) - CW'(pop);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      presc_q <= '0;
      tcnt_q  <= '0;
      bidx_q  <= '0;
      s7_q    <= 1'b1;
      s8_q    <= 1'b1;
      sh_q    <= '0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], rx};
      presc_q <= presc_d;
      tcnt_q  <= tcnt_d;
      bidx_q  <= bidx_d;
      s7_q    <= s7_d;
      s8_q    <= s8_d;
      sh_q    <= sh_d;
      fe_q    <= fe;
      ov_q    <= ov;
      wr_q    <= wr ? wr_q + 1'b1 : wr_q;
      rd_q    <= pop ? rd_q + 1'b1 : rd_q;
      cnt_q   <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_q] <= sh_q;
  end
  assign m.m_valid  = cnt_q != '0;
  assign m.m_data   = m.m_valid ? mem_q[rd_q] : '0;
  assign frame_err  = fe_q;
  assign overrun    = ov_q;
  assign fifo_count = cnt_q;
endmodule
